stack_arbiter_ctrl: RTL and testbench
=====================================

Name: stack_arbiter_ctrl

Overview:
- Controller that shares the 32-bit hardware stack between two requesters: port 0 (decode: CALL/RET, PUSH/POP instructions) and port 1 (interrupt unit: entry/RETI).
- Arbitrates, sequences single-cycle push/pop strobes into the stack, and tracks occupancy itself.
- Raises sticky overflow/underflow errors.
- Because the stack has no reset, the controller drains it after reset before accepting requests.

Parameters:
DATA_W, 32, stack word width
DEPTH, 15, usable stack entries (the stack is full at pointer 15)
CNT_W, 4, occupancy counter width; must hold DEPTH
FLUSH_MAX, 16, maximum pops issued while draining before declaring failure

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
req0_valid  in  1  port 0 request
req0_pop  in  1  port 0 op: 0 = push, 1 = pop
req0_data  in  DATA_W  port 0 push data
req0_ready  out  1  port 0 accept; transfer when valid and ready
resp0_valid  out  1  one-cycle port 0 completion pulse
resp0_err  out  1  port 0 op rejected (overflow/underflow), qualified by resp0_valid
req1_valid, req1_pop, req1_data, req1_ready, resp1_valid, resp1_err  same as port 0, for port 1
resp_data  out  DATA_W  popped word, shared, qualified by either resp*_valid
stk_push  out  1  push strobe to stack
stk_pop  out  1  pop strobe to stack
stk_din  out  DATA_W  push data to stack
stk_dout  in  DATA_W  stack top-of-stack output
stk_is_empty  in  1  stack empty flag (registered, lags pointer by one cycle)
count  out  CNT_W  current occupancy
busy  out  1  high in every state except IDLE
err_overflow  out  1  sticky: push attempted at count == DEPTH
err_underflow  out  1  sticky: pop attempted at count == 0
err_flush  out  1  sticky: drain failed
err_clr  in  1  clears all three sticky errors (has priority over setting)

Behaviour:
- Reset (async): state FLUSH; count 0; all strobes, readys and resp pulses 0; resp_data 0; errors 0; last_grant = 1, so port 0 wins the first tie.
- FLUSH: alternates POP cycle (stk_pop = 1) and WAIT cycle, because stk_is_empty lags.
  - Samples stk_is_empty on each WAIT cycle.
  - stk_is_empty = 1 → IDLE.
  - After FLUSH_MAX pops with the stack still non-empty → set err_flush, go to IDLE.
- IDLE: readyN is asserted combinationally for the granted port only.
  - Grant rule: only one valid → it wins. Both valid → the port not equal to last_grant wins (round-robin).
  - On transfer: latch port, op and data; update last_grant; go to ISSUE.
- ISSUE (1 cycle):
  - Legal push (count < DEPTH): stk_push = 1, stk_din = latched data, count + 1.
  - Legal pop (count > 0): capture stk_dout into resp_data, stk_pop = 1, count − 1.
  - Illegal op: no strobe, count unchanged, set the matching sticky error, mark response err.
  - Next state: SETTLE.
- SETTLE (1 cycle): respN_valid = 1 for the latched port; respN_err per ISSUE outcome; then IDLE.
- Latency and throughput: 1 op per 3 cycles. Accept at cycle t, strobe at t+1, response at t+2, next accept at t+3.
- Strobe exclusivity: stk_push and stk_pop are never high together. Count never wraps (saturating guards above).
- err_clr and a new error in the same cycle: clear wins; the error is still reported via respN_err.
- Reset asserted mid-operation:
  - Any in-flight strobe or response is dropped immediately, with no response pulse.
  - The controller re-enters FLUSH after reset deasserts.
- Requests presented during FLUSH/ISSUE/SETTLE are held by the requester (ready = 0); valid must remain stable until ready.

Decomposition:
- Shared package stack_ctrl_pkg:
  - state encoding: FLUSH_POP, FLUSH_WAIT, IDLE, ISSUE, SETTLE
  - op constants: OP_PUSH = 0, OP_POP = 1
  - DEPTH and FLUSH_MAX defaults
- Sub-module rr_arbiter2: 2-requester round-robin grant with last_grant register, updated on transfer only.
- FSM, occupancy counter and error logic stay in the top module.

Test Plan:
- Reset release with a pre-loaded stack (3 entries left from a previous run) → exactly 3 stk_pop strobes on alternate cycles, then busy = 0, count = 0.
- Port 0 pushes 0xDEADBEEF then 0x12345678, then pops twice → resp_data 0x12345678 then 0xDEADBEEF, resp0_err = 0, count returns to 0, each response 2 cycles after accept.
- Both ports valid continuously (port 0 pushes, port 1 pushes) → grants 0, 1, 0, 1 alternate; count increments by 1 per 3 cycles.
- 15 pushes, then a 16th push → 16th gives resp_err = 1, err_overflow = 1, no stk_push, count stays 15. err_clr → err_overflow = 0.
- Pop at count 0 → resp_err = 1, err_underflow = 1, no stk_pop, resp_data unchanged.
- rst asserted during ISSUE of a push → strobes drop within the same cycle, no resp pulse, FLUSH runs after release; a stuck-low stk_is_empty model gives err_flush = 1 after 16 pops.

Source files
------------

// File: rtl/stack_arbiter_ctrl_pkg.sv
// Shared definitions for the stack arbiter controller: FSM states, op codes
// and default sizing of the hardware stack.
package stack_ctrl_pkg;

   typedef enum logic [2:0] {
      FLUSH_POP  = 3'd0,
      FLUSH_WAIT = 3'd1,
      IDLE       = 3'd2,
      ISSUE      = 3'd3,
      SETTLE     = 3'd4
   } state_t;

   localparam logic OP_PUSH = 1'b0;
   localparam logic OP_POP  = 1'b1;

   localparam int DEPTH_DEFAULT     = 15;
   localparam int FLUSH_MAX_DEFAULT = 16;

endpackage

// File: rtl/stack_arbiter_ctrl_if.sv
// Requester-side bundle: two request/response ports sharing one popped-data bus.
interface stack_arbiter_ctrl_if #(
   parameter int DATA_W = 32
);
   logic              req0_valid;
   logic              req0_pop;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;
   logic              resp0_valid;
   logic              resp0_err;

   logic              req1_valid;
   logic              req1_pop;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;
   logic              resp1_valid;
   logic              resp1_err;

   logic [DATA_W-1:0] resp_data;

   modport master (
      output req0_valid, req0_pop, req0_data, req1_valid, req1_pop, req1_data,
      input  req0_ready, resp0_valid, resp0_err, req1_ready, resp1_valid, resp1_err,
      input  resp_data
   );

   modport slave (
      input  req0_valid, req0_pop, req0_data, req1_valid, req1_pop, req1_data,
      output req0_ready, resp0_valid, resp0_err, req1_ready, resp1_valid, resp1_err,
      output resp_data
   );
endinterface

// File: rtl/stack_arbiter_ctrl_rr_arbiter2.sv
// Two-requester round-robin arbiter. A lone requester always wins; on a tie
// the port that did not win the last transfer is granted.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       xfer,
   output logic       grant
);
   logic last_grant_q;
   logic last_grant_d;

   // Grant selection: single requester wins, tie goes away from last winner
   always_comb begin
      grant = 1'b0;
      if (req[0] && req[1]) begin
         grant = ~last_grant_q;
      end else if (req[1]) begin
         grant = 1'b1;
      end else begin
         grant = 1'b0;
      end
   end

   // Remember the winner only when its transfer actually happens
   always_comb begin
      last_grant_d = last_grant_q;
      if (xfer) begin
         last_grant_d = grant;
      end else begin
         last_grant_d = last_grant_q;
      end
   end

   // last_grant starts at 1 so port 0 wins the first tie
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
endmodule

// File: rtl/stack_arbiter_ctrl.sv
// Shares one hardware stack between decode (port 0) and the interrupt unit
// (port 1). Drains the unreset stack after reset, then serves one op every
// three cycles: accept, strobe, respond. Tracks occupancy and sticky errors.
module stack_arbiter_ctrl
   import stack_ctrl_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = DEPTH_DEFAULT,
   parameter int CNT_W     = 4,
   parameter int FLUSH_MAX = FLUSH_MAX_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   stack_arbiter_ctrl_if.slave bus,
   output logic              stk_push,
   output logic              stk_pop,
   output logic [DATA_W-1:0] stk_din,
   input  logic [DATA_W-1:0] stk_dout,
   input  logic              stk_is_empty,
   output logic [CNT_W-1:0]  count,
   output logic              busy,
   output logic              err_overflow,
   output logic              err_underflow,
   output logic              err_flush,
   input  logic              err_clr
);
   localparam int               FC_W        = $clog2(FLUSH_MAX + 1);
   localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
   localparam logic [FC_W-1:0]  FLUSH_MAX_C = FC_W'(FLUSH_MAX);
   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};

   state_t              state_q, state_d;
   logic                port_q, port_d;
   logic                op_q, op_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [FC_W-1:0]     flush_cnt_q, flush_cnt_d;
   logic [DATA_W-1:0]   resp_data_q, resp_data_d;
   logic                stk_push_q, stk_push_d;
   logic                stk_pop_q, stk_pop_d;
   logic                resp0_valid_q, resp0_valid_d;
   logic                resp1_valid_q, resp1_valid_d;
   logic                resp0_err_q, resp0_err_d;
   logic                resp1_err_q, resp1_err_d;
   logic                busy_q, busy_d;
   logic                err_ovf_q, err_ovf_d;
   logic                err_udf_q, err_udf_d;
   logic                err_flush_q, err_flush_d;

   logic                grant_s;
   logic                xfer_s;
   logic                ovf_set_s;
   logic                udf_set_s;
   logic                flush_fail_s;

   // Transfer happens in IDLE whenever any port is requesting
   assign xfer_s = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);

   rr_arbiter2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   ({bus.req1_valid, bus.req0_valid}),
      .xfer  (xfer_s),
      .grant (grant_s)
   );

   assign bus.req0_ready  = xfer_s && (grant_s == 1'b0);
   assign bus.req1_ready  = xfer_s && (grant_s == 1'b1);
   assign bus.resp0_valid = resp0_valid_q;
   assign bus.resp1_valid = resp1_valid_q;
   assign bus.resp0_err   = resp0_err_q;
   assign bus.resp1_err   = resp1_err_q;
   assign bus.resp_data   = resp_data_q;
   assign stk_push        = stk_push_q;
   assign stk_pop         = stk_pop_q;
   assign stk_din         = data_q;
   assign count           = count_q;
   assign busy            = busy_q;
   assign err_overflow    = err_ovf_q;
   assign err_underflow   = err_udf_q;
   assign err_flush       = err_flush_q;

   // Next state, datapath updates, and the registered view of the next cycle's outputs
   always_comb begin
      state_d      = state_q;
      port_d       = port_q;
      op_d         = op_q;
      data_d       = data_q;
      count_d      = count_q;
      flush_cnt_d  = flush_cnt_q;
      resp_data_d  = resp_data_q;
      ovf_set_s    = 1'b0;
      udf_set_s    = 1'b0;
      flush_fail_s = 1'b0;

      case (state_q)
         FLUSH_WAIT: begin
            // The empty flag is valid here because the previous pop has settled
            if (stk_is_empty) begin
               state_d = IDLE;
            end else if (flush_cnt_q == FLUSH_MAX_C) begin
               flush_fail_s = 1'b1;
               state_d      = IDLE;
            end else begin
               state_d = FLUSH_POP;
            end
         end
         FLUSH_POP: begin
            flush_cnt_d = flush_cnt_q + FC_W'(1);
            state_d     = FLUSH_WAIT;
         end
         IDLE: begin
            if (xfer_s) begin
               port_d  = grant_s;
               state_d = ISSUE;
               if (grant_s) begin
                  op_d   = bus.req1_pop;
                  data_d = bus.req1_data;
               end else begin
                  op_d   = bus.req0_pop;
                  data_d = bus.req0_data;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (op_q == OP_PUSH) begin
               if (count_q < DEPTH_C) begin
                  count_d = count_q + CNT_W'(1);
               end else begin
                  ovf_set_s = 1'b1;
               end
            end else begin
               if (count_q != CNT_ZERO) begin
                  count_d     = count_q - CNT_W'(1);
                  resp_data_d = stk_dout;
               end else begin
                  udf_set_s = 1'b1;
               end
            end
            state_d = SETTLE;
         end
         SETTLE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = FLUSH_WAIT;
         end
      endcase

      // Strobe legality is known at accept time since count only moves in ISSUE
      stk_push_d    = (state_d == ISSUE) && (op_d == OP_PUSH) && (count_q < DEPTH_C);
      stk_pop_d     = (state_d == FLUSH_POP) ||
                      ((state_d == ISSUE) && (op_d == OP_POP) && (count_q != CNT_ZERO));
      resp0_valid_d = (state_d == SETTLE) && (port_q == 1'b0);
      resp1_valid_d = (state_d == SETTLE) && (port_q == 1'b1);
      resp0_err_d   = resp0_valid_d && (ovf_set_s || udf_set_s);
      resp1_err_d   = resp1_valid_d && (ovf_set_s || udf_set_s);
      busy_d        = (state_d != IDLE);

      // Clear beats a same-cycle set; the response still carries the error
      err_ovf_d   = err_clr ? 1'b0 : (err_ovf_q   | ovf_set_s);
      err_udf_d   = err_clr ? 1'b0 : (err_udf_q   | udf_set_s);
      err_flush_d = err_clr ? 1'b0 : (err_flush_q | flush_fail_s);
   end

   // State and output registers; reset lands in FLUSH_WAIT so no strobe fires during reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= FLUSH_WAIT;
         port_q        <= 1'b0;
         op_q          <= OP_PUSH;
         data_q        <= {DATA_W{1'b0}};
         count_q       <= CNT_ZERO;
         flush_cnt_q   <= {FC_W{1'b0}};
         resp_data_q   <= {DATA_W{1'b0}};
         stk_push_q    <= 1'b0;
         stk_pop_q     <= 1'b0;
         resp0_valid_q <= 1'b0;
         resp1_valid_q <= 1'b0;
         resp0_err_q   <= 1'b0;
         resp1_err_q   <= 1'b0;
         busy_q        <= 1'b1;
         err_ovf_q     <= 1'b0;
         err_udf_q     <= 1'b0;
         err_flush_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         port_q        <= port_d;
         op_q          <= op_d;
         data_q        <= data_d;
         count_q       <= count_d;
         flush_cnt_q   <= flush_cnt_d;
         resp_data_q   <= resp_data_d;
         stk_push_q    <= stk_push_d;
         stk_pop_q     <= stk_pop_d;
         resp0_valid_q <= resp0_valid_d;
         resp1_valid_q <= resp1_valid_d;
         resp0_err_q   <= resp0_err_d;
         resp1_err_q   <= resp1_err_d;
         busy_q        <= busy_d;
         err_ovf_q     <= err_ovf_d;
         err_udf_q     <= err_udf_d;
         err_flush_q   <= err_flush_d;
      end
   end
endmodule

// File: tb/tb_stack_arbiter_ctrl.sv
// Bench for stack_arbiter_ctrl: a behavioural stack device, a queue-based
// reference model, a directed vector table, arbitration/overflow/reset
// sequences and a randomized run.
module tb_stack_arbiter_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stk_push, stk_pop;
   logic [31:0] stk_din, stk_dout;
   logic        stk_is_empty;
   logic [3:0]  count;
   logic        busy, err_overflow, err_underflow, err_flush;
   logic        err_clr = 1'b0;

   always #5 clk = ~clk;

   stack_arbiter_ctrl_if #(.DATA_W(32)) bus ();

   stack_arbiter_ctrl #(.DATA_W(32), .DEPTH(15), .CNT_W(4), .FLUSH_MAX(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .stk_push      (stk_push),
      .stk_pop       (stk_pop),
      .stk_din       (stk_din),
      .stk_dout      (stk_dout),
      .stk_is_empty  (stk_is_empty),
      .count         (count),
      .busy          (busy),
      .err_overflow  (err_overflow),
      .err_underflow (err_underflow),
      .err_flush     (err_flush),
      .err_clr       (err_clr)
   );

   // ---------------- stack device (no reset, registered empty flag) ----------
   logic [31:0] mem [0:15];
   int          ptr = 0;
   int          np_s;
   logic        empty_q = 1'b1;
   bit          load_en = 1'b0;
   int          load_n = 0;
   bit          stuck_low = 1'b0;

   // Next pointer of the stack device
   always_comb begin
      if (stk_push && ptr < 16)     np_s = ptr + 1;
      else if (stk_pop && ptr > 0)  np_s = ptr - 1;
      else                          np_s = ptr;
   end

   // Stack storage, pointer and empty flag
   always @(posedge clk) begin
      if (load_en) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h5A00_0000 + i;
         ptr     <= load_n;
         empty_q <= (load_n == 0);
      end else begin
         if (stk_push && ptr < 16) mem[ptr] <= stk_din;
         ptr     <= np_s;
         empty_q <= stuck_low ? 1'b0 : (np_s == 0);
      end
   end

   assign stk_is_empty = empty_q;
   assign stk_dout     = (ptr > 0) ? mem[ptr-1] : 32'h0;

   // ---------------- reference model ---------------------------------------
   logic [31:0] mq[$];
   logic [31:0] m_last_resp = 32'h0;
   bit          m_ovf = 1'b0;
   bit          m_udf = 1'b0;
   int          m_last_win = 1;

   int n_pass = 0;
   int n_checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   task automatic drive_port(input int port, input bit v, input bit pop, input logic [31:0] d);
      if (port == 0) begin
         bus.req0_valid = v; bus.req0_pop = pop; bus.req0_data = d;
      end else begin
         bus.req1_valid = v; bus.req1_pop = pop; bus.req1_data = d;
      end
   endtask

   // One complete operation on one port, checked cycle by cycle against the model
   task automatic run_op(input int port, input bit pop, input logic [31:0] d, input bit clr_issue,
                         output bit got_err, output logic [31:0] got_data, output int got_count);
      bit exp_err;
      bit rdy;
      int waited;
      exp_err = pop ? (mq.size() == 0) : (mq.size() == 15);
      got_err = 1'b0; got_data = 32'h0; got_count = 0;
      @(negedge clk);
      drive_port(port, 1'b1, pop, d);
      #1;
      waited = 0;
      rdy = (port == 0) ? bus.req0_ready : bus.req1_ready;
      while (!rdy && waited < 20) begin
         @(negedge clk); #1;
         waited++;
         rdy = (port == 0) ? bus.req0_ready : bus.req1_ready;
      end
      check("accept_wait", waited, 0);
      if (!rdy) begin
         drive_port(port, 1'b0, 1'b0, 32'h0);
         return;
      end
      check("other_ready", (port == 0) ? bus.req1_ready : bus.req0_ready, 0);
      @(negedge clk);
      drive_port(port, 1'b0, 1'b0, 32'h0);
      if (clr_issue) err_clr = 1'b1;
      #1;
      check("stk_push", stk_push, (!pop && !exp_err));
      check("stk_pop", stk_pop, (pop && !exp_err));
      if (!pop && !exp_err) check("stk_din", stk_din, d);
      check("resp_early", bus.resp0_valid | bus.resp1_valid, 0);
      if (clr_issue) begin
         m_ovf = 1'b0; m_udf = 1'b0;
      end
      if (pop) begin
         if (!exp_err) m_last_resp = mq.pop_back();
         else if (!clr_issue) m_udf = 1'b1;
      end else begin
         if (!exp_err) mq.push_back(d);
         else if (!clr_issue) m_ovf = 1'b1;
      end
      m_last_win = port;
      @(negedge clk);
      err_clr = 1'b0;
      #1;
      check("resp_valid", (port == 0) ? bus.resp0_valid : bus.resp1_valid, 1);
      check("resp_other", (port == 0) ? bus.resp1_valid : bus.resp0_valid, 0);
      got_err   = (port == 0) ? bus.resp0_err : bus.resp1_err;
      got_data  = bus.resp_data;
      got_count = int'(count);
      check("resp_err", got_err, exp_err);
      check("resp_data", got_data, m_last_resp);
      check("count", count, mq.size());
      check("err_overflow", err_overflow, m_ovf);
      check("err_underflow", err_underflow, m_udf);
   endtask

   task automatic pulse_clr();
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0; #1;
      m_ovf = 1'b0; m_udf = 1'b0;
      check("clr_ovf", err_overflow, 0);
      check("clr_udf", err_underflow, 0);
      check("clr_flush", err_flush, 0);
   endtask

   typedef struct {
      int          port;
      bit          pop;
      logic [31:0] data;
      bit          exp_err;
      logic [31:0] exp_data;
      int          exp_count;
   } vec_t;

   vec_t tbl[5];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit          e;
      logic [31:0] dd;
      int          c;
      int          pops, consec, waited, win, exp_win, base;
      bit          prev;
      time         t_prev;

      bus.req0_valid = 1'b0; bus.req0_pop = 1'b0; bus.req0_data = 32'h0;
      bus.req1_valid = 1'b0; bus.req1_pop = 1'b0; bus.req1_data = 32'h0;

      // ---- reset with a pre-loaded stack of 3 entries ----
      load_en = 1'b1; load_n = 3;
      #1 rst = 1'b1;
      bus.req1_valid = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_ready0", bus.req0_ready, 0);
      check("rst_ready1", bus.req1_ready, 0);
      check("rst_push", stk_push, 0);
      check("rst_pop", stk_pop, 0);
      check("rst_resp", bus.resp0_valid | bus.resp1_valid, 0);
      check("rst_count", count, 0);
      check("rst_resp_data", bus.resp_data, 0);
      check("rst_errs", {err_overflow, err_underflow, err_flush}, 0);
      bus.req1_valid = 1'b0;
      load_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      pops = 0; consec = 0; prev = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk); #1;
         if (stk_pop) begin
            pops++;
            if (prev) consec++;
         end
         prev = stk_pop;
         if (!busy) break;
      end
      check("flush_pops", pops, 3);
      check("flush_alternate", consec, 0);
      check("flush_done_busy", busy, 0);
      check("flush_count", count, 0);
      check("flush_err", err_flush, 0);

      // ---- directed vector table ----
      tbl[0] = '{0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0000_0000, 1};
      tbl[1] = '{0, 1'b0, 32'h12345678, 1'b0, 32'h0000_0000, 2};
      tbl[2] = '{0, 1'b1, 32'h0000_0000, 1'b0, 32'h12345678, 1};
      tbl[3] = '{0, 1'b1, 32'h0000_0000, 1'b0, 32'hDEADBEEF, 0};
      tbl[4] = '{1, 1'b1, 32'h0000_0000, 1'b1, 32'hDEADBEEF, 0};
      for (int i = 0; i < 5; i++) begin
         run_op(tbl[i].port, tbl[i].pop, tbl[i].data, 1'b0, e, dd, c);
         check("vec_err", e, tbl[i].exp_err);
         check("vec_data", dd, tbl[i].exp_data);
         check("vec_count", c, tbl[i].exp_count);
      end
      check("underflow_sticky", err_underflow, 1);
      pulse_clr();

      // ---- both ports pushing continuously: round-robin alternation ----
      @(negedge clk);
      drive_port(0, 1'b1, 1'b0, 32'hA0A0_0000);
      drive_port(1, 1'b1, 1'b0, 32'hB1B1_0000);
      base = mq.size();
      exp_win = 1 - m_last_win;
      t_prev = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         waited = 0;
         while (!(bus.req0_ready | bus.req1_ready) && waited < 10) begin
            @(negedge clk); #1; waited++;
         end
         win = bus.req1_ready ? 1 : 0;
         check("arb_grant", win, exp_win);
         check("arb_onehot", bus.req0_ready & bus.req1_ready, 0);
         check("arb_count", count, base + i);
         if (i > 0) check("arb_gap", 32'($time - t_prev), 30);
         t_prev = $time;
         mq.push_back(win == 1 ? 32'hB1B1_0000 : 32'hA0A0_0000);
         m_last_win = win;
         exp_win = 1 - win;
         @(negedge clk);
      end
      drive_port(0, 1'b0, 1'b0, 32'h0);
      drive_port(1, 1'b0, 1'b0, 32'h0);
      @(negedge clk); #1;
      check("arb_final_count", count, mq.size());

      // ---- randomized operations against the model ----
      for (int i = 0; i < 40; i++) begin
         run_op(int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), $urandom, 1'b0, e, dd, c);
      end
      pulse_clr();

      // ---- fill to DEPTH, then overflow ----
      while (mq.size() < 15) run_op(int'($urandom_range(1, 0)), 1'b0, $urandom, 1'b0, e, dd, c);
      run_op(0, 1'b0, 32'hCAFE_0016, 1'b0, e, dd, c);
      check("ovf_err", e, 1);
      check("ovf_count", c, 15);
      check("ovf_sticky", err_overflow, 1);
      pulse_clr();
      run_op(1, 1'b0, 32'hCAFE_0017, 1'b1, e, dd, c);
      check("ovf_clr_same_cycle_err", e, 1);
      check("ovf_clr_same_cycle_flag", err_overflow, 0);

      // ---- reset during ISSUE of a push, then a drain that never empties ----
      run_op(0, 1'b1, 32'h0, 1'b0, e, dd, c);
      @(negedge clk);
      drive_port(0, 1'b1, 1'b0, 32'h7777_0001);
      #1;
      check("rst_mid_accept", bus.req0_ready, 1);
      @(negedge clk);
      drive_port(0, 1'b0, 1'b0, 32'h0);
      #1;
      check("rst_mid_push_before", stk_push, 1);
      stuck_low = 1'b1;
      rst = 1'b1;
      #1;
      check("rst_mid_push_drop", stk_push, 0);
      check("rst_mid_pop_drop", stk_pop, 0);
      check("rst_mid_count", count, 0);
      pops = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         if (bus.resp0_valid | bus.resp1_valid) pops++;
      end
      check("rst_mid_no_resp", pops, 0);
      rst = 1'b0;
      pops = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (stk_pop) pops++;
         if (!busy) break;
      end
      check("stuck_pops", pops, 16);
      check("stuck_busy", busy, 0);
      check("stuck_err_flush", err_flush, 1);
      check("stuck_count", count, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
